// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Turns memory-data stall requests into a per-stage stall vector. When the
//   HAZARD_CTRL_FLUSH_EN macro is defined, it also issues a one-cycle branch
//   flush of the youngest FLUSH_DEPTH stages. A flush requested while stalled
//   is deferred until the stall has fully drained.
// Parameters:
//   NUM_STAGES  - stages driven (bit 0 = ID), 2..8
//   CNT_W       - width of the stall request and counter
//   FLUSH_DEPTH - number of low-index stages flushed on a branch, 1..NUM_STAGES
// Ports:
//   clk               - clock, rising edge
//   rst               - asynchronous active-high reset
//   i_mem_data_access - stall cycles requested (0 = none); reloads the counter
//   i_mem_ready       - early completion; clears an active stall
//   i_branch_met      - branch taken (ignored unless HAZARD_CTRL_FLUSH_EN)
//   o_stall_r         - registered per-stage stall
//   o_flush_r         - registered per-stage flush pulse
//   o_busy            - combinational, high while the stall counter is nonzero
module hazard_ctrl #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      i_mem_data_access,
    input  logic                  i_mem_ready,
    input  logic                  i_branch_met,
    output logic [NUM_STAGES-1:0] o_stall_r,
    output logic [NUM_STAGES-1:0] o_flush_r,
    output logic                  o_busy
);

`ifdef HAZARD_CTRL_FLUSH_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [NUM_STAGES-1:0] FLUSH_MASK =
        NUM_STAGES'((32'd1 << FLUSH_DEPTH) - 32'd1);
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    // Flush path is compiled out; these inputs/parameters are intentionally unused.
    localparam int unsigned unused_flush_depth = FLUSH_DEPTH;
    logic unused_branch_met;
    assign unused_branch_met = i_branch_met;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_valid;

`ifdef HAZARD_CTRL_FLUSH_EN
    logic pend_q, pend_d;
`endif

    assign req_valid = |i_mem_data_access;
    assign o_busy    = |cnt_q;

    // Next-state / counter logic; a nonzero request always reloads the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef HAZARD_CTRL_FLUSH_EN
        pend_d  = pend_q;
`endif
        if (req_valid) begin
            cnt_d   = i_mem_data_access;
            state_d = S_STALL;
`ifdef HAZARD_CTRL_FLUSH_EN
            // A branch arriving with a load is deferred; the flushed slot can't branch.
            if (i_branch_met && (state_q != S_FLUSH)) begin
                pend_d = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef HAZARD_CTRL_FLUSH_EN
                    if (i_branch_met || pend_q) begin
                        state_d = S_FLUSH;
                        pend_d  = 1'b0;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                S_STALL: begin
                    if (i_mem_ready || (cnt_q == '0)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    state_d = (cnt_d == '0) ? S_IDLE : S_STALL;
`ifdef HAZARD_CTRL_FLUSH_EN
                    if (i_branch_met) begin
                        pend_d = 1'b1;
                    end
`endif
                end
`ifdef HAZARD_CTRL_FLUSH_EN
                S_FLUSH: begin
                    state_d = S_IDLE;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs. Stall mirrors o_busy one cycle late,
    // so a flush (entered only from IDLE with the counter at 0) never overlaps it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            o_stall_r <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            o_stall_r <= {NUM_STAGES{o_busy}};
        end
    end

`ifdef HAZARD_CTRL_FLUSH_EN
    // Pending-flush flag and one-cycle flush pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            o_flush_r <= '0;
        end else begin
            pend_q    <= pend_d;
            o_flush_r <= (state_d == S_FLUSH) ? FLUSH_MASK : '0;
        end
    end
`else
    assign o_flush_r = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized stimulus checked against
// a cycle-level behavioural model of the hazard controller.
module tb_hazard_ctrl;

    localparam int unsigned NUM_STAGES  = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned FLUSH_DEPTH = 2;

`ifdef HAZARD_CTRL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CNT_W-1:0]      mem_req = '0;
    logic                  mem_rdy = 1'b0;
    logic                  br_met  = 1'b0;
    logic [NUM_STAGES-1:0] stall_r;
    logic [NUM_STAGES-1:0] flush_r;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: remaining stall cycles, deferred flush, flush cycle.
    int                    m_rem      = 0;
    bit                    m_pend     = 1'b0;
    bit                    m_flushing = 1'b0;
    logic [NUM_STAGES-1:0] m_stall    = '0;
    logic [NUM_STAGES-1:0] m_flush    = '0;
    logic [NUM_STAGES-1:0] flush_mask;

    hazard_ctrl #(
        .NUM_STAGES (NUM_STAGES),
        .CNT_W      (CNT_W),
        .FLUSH_DEPTH(FLUSH_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_mem_data_access(mem_req),
        .i_mem_ready      (mem_rdy),
        .i_branch_met     (br_met),
        .o_stall_r        (stall_r),
        .o_flush_r        (flush_r),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem      = 0;
        m_pend     = 1'b0;
        m_flushing = 1'b0;
        m_stall    = '0;
        m_flush    = '0;
    endtask

    // One rising edge of the reference model with the sampled inputs.
    task automatic model_edge(input int req, input bit rdy, input bit br);
        bit flush_now;
        flush_now = 1'b0;
        // Stall output shows whether any stall cycles were outstanding before the edge.
        m_stall = (m_rem > 0) ? '1 : '0;
        if (req != 0) begin
            m_rem = req;
            if (FLUSH_EN && br && !m_flushing) m_pend = 1'b1;
        end else if (m_rem > 0) begin
            m_rem = rdy ? 0 : m_rem - 1;
            if (FLUSH_EN && br) m_pend = 1'b1;
        end else if (FLUSH_EN && !m_flushing && (br || m_pend)) begin
            flush_now = 1'b1;
            m_pend    = 1'b0;
        end
        m_flushing = flush_now;
        m_flush    = flush_now ? flush_mask : '0;
    endtask

    task automatic compare_outputs();
        check("stall_r", 32'(stall_r), 32'(m_stall));
        check("flush_r", 32'(flush_r), 32'(m_flush));
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("no_overlap", 32'(|(stall_r & flush_r)), 32'd0);
    endtask

    // Apply inputs for one cycle, advance the model at the edge, check after it.
    task automatic step(input int req, input bit rdy, input bit br);
        @(negedge clk);
        mem_req = CNT_W'(req);
        mem_rdy = rdy;
        br_met  = br;
        @(posedge clk);
        model_edge(req, rdy, br);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        mem_req = '0;
        mem_rdy = 1'b0;
        br_met  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall", 32'(stall_r), 32'd0);
        check("rst_flush", 32'(flush_r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        flush_mask = NUM_STAGES'((32'd1 << FLUSH_DEPTH) - 32'd1);
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("por_stall", 32'(stall_r), 32'd0);
        check("por_flush", 32'(flush_r), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic stall: first request right after reset release
        step(3, 1'b0, 1'b0);
        idle(5);

        // Early release on the 3rd stall cycle
        step(8, 1'b0, 1'b0);
        idle(2);
        step(0, 1'b1, 1'b0);
        idle(3);

        // Reload shortens the stall
        step(5, 1'b0, 1'b0);
        idle(1);
        step(2, 1'b0, 1'b0);
        idle(4);

        // Ready and request together: request wins
        step(6, 1'b0, 1'b0);
        step(3, 1'b1, 1'b0);
        idle(5);

        // Deferred branch during a 4-cycle stall, with repeated branches
        step(4, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        idle(5);

        // Branch in idle; request arriving during the flush cycle
        step(0, 1'b0, 1'b1);
        step(2, 1'b0, 1'b0);
        idle(4);

        // Branch together with a request in idle: load wins, flush deferred
        step(3, 1'b0, 1'b1);
        idle(6);

        // Saturation: all-ones request stalls 15 cycles without wrapping
        step(15, 1'b0, 1'b0);
        idle(18);

        // Reset mid-stall with a pending flush: nothing after release
        step(6, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);
        idle(1);
        async_reset();
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int req;
            bit rdy;
            bit br;
            req = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 0;
            rdy = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            step(req, rdy, br);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
